// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store memory stage.
//   - RISC-V funct3 width/sign encodings used by loads and stores
//   - LSU state encoding (kept as plain 2-bit constants)
//   - default access timeout
package lsu_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam int LSU_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension (combinational).
//   mem_rdata : raw 32-bit word from memory
//   funct3    : load width/sign encoding
//   addr_lo   : low two address bits of the access
//   rdata_ext : selected byte/half/word, sign- or zero-extended
// Also used by the writeback mux, so it has no state of its own.
module lsu_load_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (addr_lo)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        rdata_ext = mem_rdata;
        case (funct3)
            F3_B:  rdata_ext = {{24{w_byte[7]}}, w_byte};
            F3_BU: rdata_ext = {24'h0, w_byte};
            F3_H:  rdata_ext = {{16{w_half[15]}}, w_half};
            F3_HU: rdata_ext = {16'h0, w_half};
            default: rdata_ext = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage behind the ALU.
//   req_valid/req_ready, is_store, funct3, addr, wdata : core request
//   stall                                              : freeze PC while busy
//   done, rdata, err_misalign, err_timeout             : completion report
//   mem_req/we/addr/wdata/wstrb, mem_gnt               : memory request channel
//   mem_rvalid, mem_rdata                              : memory load response
// Misaligned/unsupported accesses never reach memory; they report through ERR.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
    parameter int CNT_W          = 7
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    logic [1:0]       r_state;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic [CNT_W-1:0] r_cnt;

    logic        w_accept;
    logic        w_misalign;
    logic        w_tmo;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_rdata_ext;

    assign req_ready = (r_state == IDLE);
    assign stall     = req_valid || (r_state != IDLE);
    assign w_accept  = req_valid && req_ready;
    // Counter holds cycles already spent in the state; the last allowed one aborts.
    assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Unsupported encodings are reported as misaligned too.
    always_comb begin
        w_misalign = 1'b0;
        case (funct3)
            F3_B, F3_BU: w_misalign = 1'b0;
            F3_H, F3_HU: w_misalign = addr[0];
            F3_W:        w_misalign = (addr[1:0] != 2'b00);
            default:     w_misalign = 1'b1;
        endcase
        if (is_store && funct3[2])
            w_misalign = 1'b1;
    end

    // Store data is replicated across lanes so the strobe alone picks the bytes.
    always_comb begin
        w_wdata = 32'h0;
        w_wstrb = 4'b1111;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wdata = {4{wdata[7:0]}};
                    w_wstrb = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    w_wdata = {2{wdata[15:0]}};
                    w_wstrb = 4'b0011 << addr[1:0];
                end
                default: w_wdata = wdata;
            endcase
        end
    end

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .funct3    (r_funct3),
        .addr_lo   (r_addr_lo),
        .rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b0;
            r_addr_lo    <= 2'b0;
            r_cnt        <= '0;
            done         <= 1'b0;
            rdata        <= 32'h0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_wstrb    <= 4'b0;
        end else begin
            done         <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_store <= is_store;
                        r_funct3   <= funct3;
                        r_addr_lo  <= addr[1:0];
                        r_cnt      <= '0;
                        mem_addr   <= {addr[31:2], 2'b00};
                        mem_wdata  <= w_wdata;
                        mem_wstrb  <= w_wstrb;
                        mem_we     <= is_store && !w_misalign;
                        if (w_misalign) begin
                            r_state <= ERR;
                        end else begin
                            r_state <= REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // A grant on the timeout cycle still completes normally.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (r_is_store || mem_rvalid) begin
                            r_state <= IDLE;
                            done    <= 1'b1;
                            if (!r_is_store)
                                rdata <= w_rdata_ext;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= '0;
                        end
                    end else if (w_tmo) begin
                        r_state     <= IDLE;
                        mem_req     <= 1'b0;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                        done    <= 1'b1;
                        rdata   <= w_rdata_ext;
                    end else if (w_tmo) begin
                        r_state     <= IDLE;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    done         <= 1'b1;
                    err_misalign <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: the stimulus process queues expected
// memory requests and completions; the monitor process checks them on the
// falling edge whenever the DUT hands shakes with memory or pulses done.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata),
        .err_misalign(err_misalign), .err_timeout(err_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rd; logic mis; logic to; int lat; logic req; } rsp_t;
    typedef struct { logic [31:0] a; logic [31:0] wd; logic [3:0] strb; logic we; } mreq_t;

    rsp_t  rsp_q[$];
    mreq_t mem_q[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void exp_mem(input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] strb, input logic we);
        mreq_t m;
        m.a = a; m.wd = wd; m.strb = strb; m.we = we;
        mem_q.push_back(m);
    endfunction

    function automatic void exp_rsp(input logic [31:0] rd, input logic mis,
                                    input logic to, input int lat, input logic req);
        rsp_t r;
        r.rd = rd; r.mis = mis; r.to = to; r.lat = lat; r.req = req;
        rsp_q.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        logic busy;
        logic saw_req;
        int   acc_cyc;
        int   busy_cyc;
        rsp_t  r;
        mreq_t m;
        busy = 1'b0; saw_req = 1'b0; acc_cyc = 0; busy_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                chk("rst_flags", 32'({req_ready, stall, mem_req, mem_we, done,
                                      err_misalign, err_timeout, mem_wstrb}), 32'h400);
                chk("rst_mem_addr", mem_addr, 32'h0);
                chk("rst_mem_wdata", mem_wdata, 32'h0);
                chk("rst_rdata", rdata, 32'h0);
            end else begin
                if (done) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'h0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rdata", rdata, r.rd);
                        chk("err_misalign", 32'(err_misalign), 32'(r.mis));
                        chk("err_timeout", 32'(err_timeout), 32'(r.to));
                        chk("latency", 32'(cyc - acc_cyc), 32'(r.lat));
                        chk("mem_req_seen", 32'(saw_req), 32'(r.req));
                        chk("mem_req_after_done", 32'(mem_req), 32'h0);
                    end
                    busy = 1'b0;
                end
                if (busy) begin
                    chk("stall_busy", 32'(stall), 32'h1);
                    if (mem_req) saw_req = 1'b1;
                    busy_cyc++;
                    if (busy_cyc > 100) begin
                        chk("watchdog_done", 32'(busy_cyc), 32'd100);
                        busy = 1'b0;
                    end
                end
                if (mem_req && mem_gnt) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_req", 32'(mem_req), 32'h0);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_addr", mem_addr, m.a);
                        chk("mem_wstrb", 32'(mem_wstrb), 32'(m.strb));
                        chk("mem_we", 32'(mem_we), 32'(m.we));
                        if (m.we) chk("mem_wdata", mem_wdata, m.wd);
                    end
                end
                if (req_valid && req_ready) begin
                    busy = 1'b1; saw_req = 1'b0; acc_cyc = cyc; busy_cyc = 0;
                end
            end
            if (end_req && !end_done) begin
                chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
                chk("mem_queue_empty", 32'(mem_q.size()), 32'h0);
                end_done = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        wait_idle();
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // g: cycles of grant delay, rv: cycles from grant to rvalid (0 = same cycle)
    task automatic mem_resp(input int g, input int rv, input logic [31:0] word,
                            input logic stray, input logic ld);
        for (int i = 0; i < g; i++) begin
            mem_rvalid = stray;
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        if (ld && rv == 0) begin mem_rvalid = 1'b1; mem_rdata = word; end
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (ld && rv > 0) begin
            for (int i = 1; i < rv; i++) begin @(posedge clk); #1; end
            mem_rvalid = 1'b1; mem_rdata = word;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin : stim
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // SW aligned, immediate grant
        exp_mem(32'h1004, 32'hDEADBEEF, 4'b1111, 1'b1);
        exp_rsp(32'h0, 1'b0, 1'b0, 2, 1'b1);
        issue(1'b1, 3'b010, 32'h1004, 32'hDEADBEEF);
        mem_resp(0, 0, 32'h0, 1'b0, 1'b0);

        // SB top lane
        exp_mem(32'h1000, 32'hA5A5A5A5, 4'b1000, 1'b1);
        exp_rsp(32'h0, 1'b0, 1'b0, 2, 1'b1);
        issue(1'b1, 3'b000, 32'h1003, 32'h000000A5);
        mem_resp(0, 0, 32'h0, 1'b0, 1'b0);

        // SH upper half, grant delayed 2 with stray rvalid meanwhile
        exp_mem(32'h1000, 32'hBEEFBEEF, 4'b1100, 1'b1);
        exp_rsp(32'h0, 1'b0, 1'b0, 4, 1'b1);
        issue(1'b1, 3'b001, 32'h1002, 32'h1234BEEF);
        mem_resp(2, 0, 32'h0, 1'b1, 1'b0);

        // LB / LBU byte 2, rvalid 3 cycles after grant
        exp_mem(32'h2000, 32'h0, 4'b1111, 1'b0);
        exp_rsp(32'hFFFFFF80, 1'b0, 1'b0, 5, 1'b1);
        issue(1'b0, 3'b000, 32'h2002, 32'h0);
        mem_resp(0, 3, 32'h12803456, 1'b0, 1'b1);
        exp_mem(32'h2000, 32'h0, 4'b1111, 1'b0);
        exp_rsp(32'h00000080, 1'b0, 1'b0, 5, 1'b1);
        issue(1'b0, 3'b100, 32'h2002, 32'h0);
        mem_resp(0, 3, 32'h12803456, 1'b0, 1'b1);

        // Misaligned / unsupported: rdata holds previous load value
        exp_rsp(32'h00000080, 1'b1, 1'b0, 2, 1'b0);
        issue(1'b0, 3'b001, 32'h2001, 32'h0);
        exp_rsp(32'h00000080, 1'b1, 1'b0, 2, 1'b0);
        issue(1'b0, 3'b010, 32'h2002, 32'h0);
        exp_rsp(32'h00000080, 1'b1, 1'b0, 2, 1'b0);
        issue(1'b0, 3'b011, 32'h2000, 32'h0);
        exp_rsp(32'h00000080, 1'b1, 1'b0, 2, 1'b0);
        issue(1'b1, 3'b100, 32'h2000, 32'h55);

        // LH upper half with grant and rvalid together
        exp_mem(32'h2000, 32'h0, 4'b1111, 1'b0);
        exp_rsp(32'hFFFF8001, 1'b0, 1'b0, 2, 1'b1);
        issue(1'b0, 3'b001, 32'h2002, 32'h0);
        mem_resp(0, 0, 32'h80013456, 1'b0, 1'b1);

        // LW, grant after 1, rvalid 1 later
        exp_mem(32'h2000, 32'h0, 4'b1111, 1'b0);
        exp_rsp(32'hCAFEF00D, 1'b0, 1'b0, 4, 1'b1);
        issue(1'b0, 3'b010, 32'h2000, 32'h0);
        mem_resp(1, 1, 32'hCAFEF00D, 1'b0, 1'b1);

        // LW never granted: timeout 64 cycles after mem_req rises
        exp_rsp(32'hCAFEF00D, 1'b0, 1'b1, 65, 1'b1);
        issue(1'b0, 3'b010, 32'h2004, 32'h0);
        wait_idle();

        // Grant arriving on the timeout cycle completes normally
        exp_mem(32'h2008, 32'h00000011, 4'b1111, 1'b1);
        exp_rsp(32'hCAFEF00D, 1'b0, 1'b0, 65, 1'b1);
        issue(1'b1, 3'b010, 32'h2008, 32'h00000011);
        mem_resp(63, 0, 32'h0, 1'b0, 1'b0);

        // Reset while waiting for load data: no done afterwards
        exp_mem(32'h3000, 32'h0, 4'b1111, 1'b0);
        issue(1'b0, 3'b010, 32'h3000, 32'h0);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Half loads after reset
        exp_mem(32'h10, 32'h0, 4'b1111, 1'b0);
        exp_rsp(32'h00000000, 1'b0, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b101, 32'h10, 32'h0);
        mem_resp(0, 1, 32'hBEEF0000, 1'b0, 1'b1);
        exp_mem(32'h10, 32'h0, 4'b1111, 1'b0);
        exp_rsp(32'h0000BEEF, 1'b0, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b101, 32'h12, 32'h0);
        mem_resp(0, 1, 32'hBEEF0000, 1'b0, 1'b1);
        exp_mem(32'h10, 32'h0, 4'b1111, 1'b0);
        exp_rsp(32'hFFFFBEEF, 1'b0, 1'b0, 2, 1'b1);
        issue(1'b0, 3'b001, 32'h12, 32'h0);
        mem_resp(0, 0, 32'hBEEF0000, 1'b0, 1'b1);

        wait_idle();
        repeat (3) @(posedge clk);
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
